// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the reference clock: pulses RESETB, waits for lock with
// timeout and bounded retries, qualifies lock stability, then releases the PLL-domain reset.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_RESET     | PLL RESETB held low for RST_CYCLES
// S_WAIT_LOCK | RESETB released, waiting up to LOCK_TIMEOUT for lock
// S_STABLE    | lock seen, must hold for STABLE_CYCLES consecutive cycles
// S_RUN       | downstream reset released, watching for loss of lock
// S_FAULT     | retries exhausted, PLL parked in reset until restart/rst_n
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] unlock_count
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int          CW     = $clog2(MAX_P);

  localparam logic [CW-1:0] RST_TC    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_TC   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_TC = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          lock_s;

  // {pll_resetb, sys_rst_n, ready, fault} as seen while sitting in state s
  function automatic logic [3:0] outs(input state_t s);
    case (s)
      S_WAIT_LOCK, S_STABLE: outs = 4'b1000;
      S_RUN:                 outs = 4'b1110;
      S_FAULT:               outs = 4'b0001;
      default:               outs = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pll_locked};
  end

  assign lock_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RESET;
      cnt          <= '0;
      retry_count  <= 4'd0;
      unlock_count <= 8'd0;
      {pll_resetb, sys_rst_n, ready, fault} <= 4'b0000;
    end else if (restart) begin
      state       <= S_RESET;
      cnt         <= '0;
      retry_count <= 4'd0;
      {pll_resetb, sys_rst_n, ready, fault} <= outs(S_RESET);
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RST_TC) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_WAIT_LOCK);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_STABLE);
          end else if (cnt == LOCK_TC && retry_count == RETRY_MAX) begin
            state <= S_FAULT;
            cnt   <= '0;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_FAULT);
          end else if (cnt == LOCK_TC) begin
            state       <= S_RESET;
            cnt         <= '0;
            retry_count <= retry_count + 4'd1;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_RESET);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STABLE: begin
          // a dropout restarts both the stability window and the lock timeout
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_WAIT_LOCK);
          end else if (cnt == STABLE_TC) begin
            state       <= S_RUN;
            cnt         <= '0;
            retry_count <= 4'd0;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_RUN);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state <= S_RESET;
            cnt   <= '0;
            if (unlock_count != 8'hFF) unlock_count <= unlock_count + 8'd1;
            {pll_resetb, sys_rst_n, ready, fault} <= outs(S_RESET);
          end
        end
        S_FAULT: begin
        end
        default: begin
          state <= S_RESET;
          cnt   <= '0;
          {pll_resetb, sys_rst_n, ready, fault} <= outs(S_RESET);
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences start-up of the iCE40 PLL and produces the reset for the logic in the PLL output domain. It runs on the PLL reference clock, which is always present. It pulses the PLL RESETB, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing downstream reset. It then watches for loss of lock and re-sequences the PLL when it occurs. Its outputs drive the PLL RESETB pin and a reset line that the PLL-domain logic synchronizes locally.

## Interface

Parameters:
- RST_CYCLES, 16: cycles the PLL RESETB is held low per attempt (≥2).
- LOCK_TIMEOUT, 4096: cycles to wait for lock after RESETB release (≥2).
- STABLE_CYCLES, 256: consecutive cycles lock must stay high before release (≥2).
- MAX_RETRIES, 3: timeouts tolerated before FAULT (1..15).

Ports:
- clk  in  1  reference clock (PLL input clock).
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL LOCK output; asynchronous to clk.
- restart  in  1  synchronous one-cycle pulse; restarts the sequence from any state.
- pll_resetb  out  1  to PLL RESETB; 0 holds the PLL in reset.
- sys_rst_n  out  1  active-low reset for PLL-domain logic; 1 only in RUN.
- ready  out  1  1 only in RUN.
- fault  out  1  1 only in FAULT.
- retry_count  out  4  lock timeouts in the current bring-up.
- unlock_count  out  8  lock losses seen in RUN; saturates at 255.

## Operation

- pll_locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency). Only lock_s is used.
- A single counter `cnt` is sized for the largest of the three cycle parameters. It is cleared on every state entry.
- States and transitions:
  - RESET
    - pll_resetb=0.
    - When cnt==RST_CYCLES-1: go to WAIT_LOCK. Otherwise cnt++.
  - WAIT_LOCK
    - pll_resetb=1.
    - If lock_s: go to STABLE.
    - Else if cnt==LOCK_TIMEOUT-1 and retry_count==MAX_RETRIES: go to FAULT.
    - Else if cnt==LOCK_TIMEOUT-1: retry_count++ and go to RESET.
    - Else cnt++.
  - STABLE
    - pll_resetb=1.
    - If !lock_s: go to WAIT_LOCK with cnt cleared. This is a fresh timeout and does not increment retry_count.
    - Else if cnt==STABLE_CYCLES-1: go to RUN.
    - Else cnt++.
  - RUN
    - pll_resetb=1, sys_rst_n=1, ready=1.
    - retry_count is cleared on entry.
    - If !lock_s: unlock_count++ (saturating) and go to RESET. sys_rst_n and ready drop on that same edge.
  - FAULT
    - pll_resetb=0, fault=1. Terminal state.
    - Exits only on restart or rst_n.
- restart, in any state:
  - Go to RESET, clear retry_count and cnt.
  - unlock_count is preserved.
  - restart has priority over every other transition in the same cycle, including a lock loss in RUN; that loss is then not counted.
- Reset (rst_n=0), applied asynchronously and at any time including mid-sequence:
  - state=RESET, cnt=0, synchronizer flops=0.
  - pll_resetb=0, sys_rst_n=0, ready=0, fault=0, retry_count=0, unlock_count=0.

## Timing

- All outputs are registered. They change on the same clk edge on which the state register enters the new state; there is no combinational path from inputs to outputs.
- Counting convention: edge 1 is the first rising clk edge after rst_n deasserts. A state entered at edge k with cnt=0 reaches its terminal count and exits at edge k+N, where N is the parameter for that state.
- Nominal bring-up with pll_locked held at 1 throughout:
  - RESET for edges 1..16 (pll_resetb low for 16 cycles).
  - WAIT_LOCK entered at edge 16.
  - STABLE entered at edge 17.
  - RUN entered at edge 273; sys_rst_n=1 and ready=1 from that edge.
- Lock-loss latency: pll_locked falls, then 2 edges for the synchronizer, then the next edge applies the transition. sys_rst_n therefore drops 3 edges after the fall.
- Each failed attempt costs RST_CYCLES+LOCK_TIMEOUT cycles.
- A glitch on lock_s during STABLE restarts both the stability window and the timeout.

## Test plan

- pll_locked tied to 1 from reset. Required:
  - pll_resetb low for exactly 16 cycles.
  - ready and sys_rst_n rise at edge 273.
  - retry_count=0, fault=0.
- pll_locked tied to 0. Required:
  - RESET/WAIT_LOCK cycles repeat every 4112 cycles.
  - retry_count steps 1, 2, 3.
  - FAULT entered at edge 16448 with fault=1 and pll_resetb=0.
  - The state then holds indefinitely.
- In RUN, drop pll_locked for 1 cycle. Required:
  - sys_rst_n=0 three edges later.
  - unlock_count=1, state=RESET.
  - With lock restored, RUN is re-entered 273 edges after re-entering RESET.
- In STABLE, pulse pll_locked low at cnt=200. Required:
  - Return to WAIT_LOCK with no increment of retry_count.
  - A full 256-cycle stability window is required before RUN.
- In FAULT, pulse restart. Required:
  - fault=0 and retry_count=0 on the next edge.
  - Nominal bring-up follows.
  - unlock_count is unchanged.
- Assert rst_n mid-WAIT_LOCK and mid-RUN, with restart and a lock loss coinciding in RUN. Required:
  - Every output returns immediately to its reset value.
  - In the restart/lock-loss case, restart wins and unlock_count is not incremented.
